inst_encoder: RTL and testbench

- Streaming RV32I instruction encoder, the inverse of the instruction decoder.
- Takes decoded fields (`ALU_*` code from define.vh, register numbers, imm, operand types) and produces 32-bit instruction words with sequential byte addresses.
- Feeds an instruction-memory loader and the decoder round-trip test bench.
- Input and output both use valid/ready handshakes, with a 2-entry output buffer between them.

---
 rtl/inst_encoder_if.sv | 30 +++
 rtl/inst_encoder.sv | 207 ++++++++++++++++++++
 tb/tb_inst_encoder.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_encoder_if.sv
// Field-bundle input and encoded-word output handshakes of inst_encoder.
interface inst_encoder_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        alucode;
  logic [1:0]        aluop1_type;
  logic [1:0]        aluop2_type;
  logic [4:0]        srcreg1_num;
  logic [4:0]        srcreg2_num;
  logic [4:0]        dstreg_num;
  logic [31:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_ir;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, alucode, aluop1_type, aluop2_type, srcreg1_num, srcreg2_num, dstreg_num,
    output imm, out_ready,
    input  in_ready, out_valid, out_ir, out_addr
  );

  modport slave (
    input  in_valid, alucode, aluop1_type, aluop2_type, srcreg1_num, srcreg2_num, dstreg_num,
    input  imm, out_ready,
    output in_ready, out_valid, out_ir, out_addr
  );
endinterface

// File: rtl/inst_encoder.sv
// Streaming RV32I encoder: decoded fields in, 32-bit words with byte addresses out, 2-entry buffer.
// Define INST_ENC_RANGE_CHECK_EN to also reject immediates that do not fit their format.
module inst_encoder #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  inst_encoder_if.slave bus,
  input  logic          addr_clr,
  output logic          err_pulse,
  output logic          err_sticky
);
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

`ifdef INST_ENC_RANGE_CHECK_EN
  localparam bit RangeCheck = 1'b1;
`else
  localparam bit RangeCheck = 1'b0;
`endif

  // Operation codes and operand types as defined in define.vh
  localparam logic [5:0] AluLui = 6'd0,  AluJal = 6'd1,  AluJalr = 6'd2,  AluBeq = 6'd3;
  localparam logic [5:0] AluBne = 6'd4,  AluBlt = 6'd5,  AluBge = 6'd6,   AluBltu = 6'd7;
  localparam logic [5:0] AluBgeu = 6'd8, AluLb = 6'd9,   AluLh = 6'd10,   AluLw = 6'd11;
  localparam logic [5:0] AluLbu = 6'd12, AluLhu = 6'd13, AluSb = 6'd14,   AluSh = 6'd15;
  localparam logic [5:0] AluSw = 6'd16,  AluAdd = 6'd17, AluSub = 6'd18,  AluSlt = 6'd19;
  localparam logic [5:0] AluSltu = 6'd20, AluXor = 6'd21, AluOr = 6'd22,  AluAnd = 6'd23;
  localparam logic [5:0] AluSll = 6'd24, AluSrl = 6'd25, AluSra = 6'd26;
  localparam logic [1:0] OpReg = 2'd1, OpImm = 2'd2, OpPc = 2'd3;

  typedef enum logic [2:0] {FmtR, FmtI, FmtSh, FmtS, FmtB, FmtU, FmtJ} fmt_e;

  fmt_e        fmt;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic        code_ok, imm_ok, bundle_ok;
  logic [31:0] enc_ir;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;

  assign imm = bus.imm;
  assign rs1 = bus.srcreg1_num;
  assign rs2 = bus.srcreg2_num;
  assign rd  = bus.dstreg_num;

  always_comb begin
    fmt     = FmtR;
    opcode  = 7'b0110011;
    f3      = 3'b000;
    f7      = 7'b0000000;
    code_ok = 1'b1;
    case (bus.alucode)
      AluLui: begin fmt = FmtU; opcode = 7'b0110111; end
      AluAdd: begin
        if (bus.aluop1_type == OpImm && bus.aluop2_type == OpPc) begin
          fmt = FmtU; opcode = 7'b0010111;
        end else if (bus.aluop1_type == OpReg && bus.aluop2_type == OpImm) begin
          fmt = FmtI; opcode = 7'b0010011;
        end else begin
          code_ok = (bus.aluop1_type == OpReg && bus.aluop2_type == OpReg);
        end
      end
      AluSub: begin f7 = 7'b0100000; code_ok = (bus.aluop2_type == OpReg); end
      AluSlt, AluSltu, AluXor, AluOr, AluAnd, AluSll, AluSrl, AluSra: begin
        case (bus.alucode)
          AluSll:         f3 = 3'b001;
          AluSlt:         f3 = 3'b010;
          AluSltu:        f3 = 3'b011;
          AluXor:         f3 = 3'b100;
          AluSrl, AluSra: f3 = 3'b101;
          AluOr:          f3 = 3'b110;
          default:        f3 = 3'b111;
        endcase
        f7 = (bus.alucode == AluSra) ? 7'b0100000 : 7'b0000000;
        if (bus.aluop2_type == OpImm) begin
          opcode = 7'b0010011;
          fmt    = (f3 == 3'b001 || f3 == 3'b101) ? FmtSh : FmtI;
        end else begin
          code_ok = (bus.aluop2_type == OpReg);
        end
      end
      AluJal:  begin fmt = FmtJ; opcode = 7'b1101111; end
      AluJalr: begin fmt = FmtI; opcode = 7'b1100111; end
      AluBeq, AluBne, AluBlt, AluBge, AluBltu, AluBgeu: begin
        fmt    = FmtB;
        opcode = 7'b1100011;
        case (bus.alucode)
          AluBeq:  f3 = 3'b000;
          AluBne:  f3 = 3'b001;
          AluBlt:  f3 = 3'b100;
          AluBge:  f3 = 3'b101;
          AluBltu: f3 = 3'b110;
          default: f3 = 3'b111;
        endcase
      end
      AluLb, AluLh, AluLw, AluLbu, AluLhu: begin
        fmt    = FmtI;
        opcode = 7'b0000011;
        case (bus.alucode)
          AluLb:   f3 = 3'b000;
          AluLh:   f3 = 3'b001;
          AluLw:   f3 = 3'b010;
          AluLbu:  f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      AluSb, AluSh, AluSw: begin
        fmt    = FmtS;
        opcode = 7'b0100011;
        f3     = (bus.alucode == AluSb) ? 3'b000 : (bus.alucode == AluSh) ? 3'b001 : 3'b010;
      end
      default: code_ok = 1'b0;
    endcase
  end

  // Signed ranges reduce to "all bits above the field's sign bit agree"
  always_comb begin
    enc_ir = '0;
    imm_ok = 1'b1;
    case (fmt)
      FmtR:  enc_ir = {f7, rs2, rs1, f3, rd, opcode};
      FmtI: begin
        enc_ir = {imm[11:0], rs1, f3, rd, opcode};
        imm_ok = (&imm[31:11]) | ~(|imm[31:11]);
      end
      FmtSh: begin
        enc_ir = {f7, imm[4:0], rs1, f3, rd, opcode};
        imm_ok = ~(|imm[31:5]);
      end
      FmtS: begin
        enc_ir = {imm[11:5], rs2, rs1, f3, imm[4:0], opcode};
        imm_ok = (&imm[31:11]) | ~(|imm[31:11]);
      end
      FmtB: begin
        enc_ir = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opcode};
        imm_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
      end
      FmtU: begin
        enc_ir = {imm[31:12], rd, opcode};
        imm_ok = ~(|imm[11:0]);
      end
      default: begin
        enc_ir = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        imm_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
      end
    endcase
  end

  assign bundle_ok = code_ok & (imm_ok | ~RangeCheck);

  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, rd_ptr_q;
  logic [31:0]       ir_q   [2];
  logic [ADDR_W-1:0] addr_q [2];
  logic [ADDR_W-1:0] pc_q;
  logic              accept, push, pop;

  assign bus.in_ready  = (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_ir    = ir_q[rd_ptr_q];
  assign bus.out_addr  = addr_q[rd_ptr_q];

  assign accept = bus.in_valid & bus.in_ready;
  assign push   = accept & bundle_ok & ~addr_clr;
  assign pop    = bus.out_valid & bus.out_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      pc_q       <= BaseAddr;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        ir_q[i]   <= '0;
        addr_q[i] <= BaseAddr;
      end
    end else begin
      err_pulse <= accept & ~bundle_ok & ~addr_clr;
      if (addr_clr) begin
        count_q    <= 2'd0;
        wr_ptr_q   <= 1'b0;
        rd_ptr_q   <= 1'b0;
        pc_q       <= BaseAddr;
        err_sticky <= 1'b0;
      end else begin
        count_q <= count_d;
        if (push) begin
          ir_q[wr_ptr_q]   <= enc_ir;
          addr_q[wr_ptr_q] <= pc_q;
          wr_ptr_q         <= ~wr_ptr_q;
          pc_q             <= pc_q + ADDR_W'(4);
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
        if (accept && !bundle_ok) err_sticky <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed cases plus random traffic against a queue-based reference model.
module tb_inst_encoder;
  localparam int unsigned AddrW = 14;
  localparam int unsigned Base  = 0;

  localparam logic [5:0] AluLui = 6'd0,  AluJal = 6'd1,  AluJalr = 6'd2,  AluBeq = 6'd3;
  localparam logic [5:0] AluBgeu = 6'd8, AluLb = 6'd9,   AluLhu = 6'd13,  AluSb = 6'd14;
  localparam logic [5:0] AluSw = 6'd16,  AluAdd = 6'd17, AluSub = 6'd18,  AluSlt = 6'd19;
  localparam logic [5:0] AluSltu = 6'd20, AluXor = 6'd21, AluOr = 6'd22,  AluAnd = 6'd23;
  localparam logic [5:0] AluSll = 6'd24, AluSrl = 6'd25, AluSra = 6'd26;
  localparam logic [1:0] OpNone = 2'd0, OpReg = 2'd1, OpImm = 2'd2, OpPc = 2'd3;

  logic clk = 1'b0;
  logic rst, addr_clr, err_pulse, err_sticky;

  inst_encoder_if #(.ADDR_W(AddrW)) bus ();

  inst_encoder #(.ADDR_W(AddrW), .BASE_ADDR(Base)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .addr_clr  (addr_clr),
    .err_pulse (err_pulse),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0]      exp_ir[$];
  logic [AddrW-1:0] exp_addr[$];
  logic [AddrW-1:0] m_addr;
  bit               m_sticky, m_pulse;

  int unsigned br_f3[6] = '{0, 1, 4, 5, 6, 7};
  int unsigned ld_f3[5] = '{0, 1, 2, 4, 5};
  int unsigned alu_f3[8] = '{2, 3, 4, 6, 7, 1, 5, 5};  // SLT..SRA in code order

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, want);
    end
  endtask

  function automatic bit ref_encode(input logic [5:0] code, input logic [1:0] t1,
      input logic [1:0] t2, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
      input logic [31:0] imm, output logic [31:0] w);
    string       fmt;
    logic [31:0] op, f3, f7, r1, r2, d;
    bit          ok;
`ifdef INST_ENC_RANGE_CHECK_EN
    int          s;
`endif
    fmt = "R"; op = 32'h33; f3 = 0; f7 = 0; ok = 1'b1;
    r1 = 32'(rs1); r2 = 32'(rs2); d = 32'(rd);
    if (code == AluLui) begin fmt = "U"; op = 32'h37; end
    else if (code == AluAdd) begin
      if (t1 == OpImm && t2 == OpPc) begin fmt = "U"; op = 32'h17; end
      else if (t1 == OpReg && t2 == OpImm) begin fmt = "I"; op = 32'h13; end
      else ok = (t1 == OpReg && t2 == OpReg);
    end else if (code == AluSub) begin f7 = 32; ok = (t2 == OpReg); end
    else if (code >= AluSlt && code <= AluSra) begin
      f3 = alu_f3[code - AluSlt];
      f7 = (code == AluSra) ? 32 : 0;
      if (t2 == OpImm) begin
        op  = 32'h13;
        fmt = (code == AluSll || code == AluSrl || code == AluSra) ? "H" : "I";
      end else ok = (t2 == OpReg);
    end else if (code == AluJal) begin fmt = "J"; op = 32'h6f; end
    else if (code == AluJalr) begin fmt = "I"; op = 32'h67; end
    else if (code >= AluBeq && code <= AluBgeu) begin
      fmt = "B"; op = 32'h63; f3 = br_f3[code - AluBeq];
    end else if (code >= AluLb && code <= AluLhu) begin
      fmt = "I"; op = 32'h03; f3 = ld_f3[code - AluLb];
    end else if (code >= AluSb && code <= AluSw) begin
      fmt = "S"; op = 32'h23; f3 = 32'(code - AluSb);
    end else ok = 1'b0;

    case (fmt)
      "R": w = (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | op;
      "I": w = ((imm & 32'hfff) << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | op;
      "H": w = (f7 << 25) | ((imm & 32'h1f) << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | op;
      "S": w = (((imm >> 5) & 32'h7f) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12)
               | ((imm & 32'h1f) << 7) | op;
      "B": w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25) | (r2 << 20)
               | (r1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hf) << 8)
               | (((imm >> 11) & 1) << 7) | op;
      "U": w = (imm & 32'hfffff000) | (d << 7) | op;
      default: w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21)
                   | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hff) << 12) | (d << 7) | op;
    endcase

`ifdef INST_ENC_RANGE_CHECK_EN
    s = $signed(imm);
    case (fmt)
      "I", "S": if (s < -2048 || s > 2047) ok = 1'b0;
      "B":      if (s < -4096 || s > 4094 || imm[0]) ok = 1'b0;
      "J":      if (s < -(1 << 20) || s > (1 << 20) - 2 || imm[0]) ok = 1'b0;
      "U":      if ((imm % 4096) != 0) ok = 1'b0;
      "H":      if (imm > 31) ok = 1'b0;
      default:  ;
    endcase
`endif
    return ok;
  endfunction

  task automatic model_reset();
    exp_ir.delete();
    exp_addr.delete();
    m_addr   = AddrW'(Base);
    m_sticky = 1'b0;
    m_pulse  = 1'b0;
  endtask

  task automatic drive(input logic [5:0] code, input logic [1:0] t1, input logic [1:0] t2,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm);
    bus.in_valid    = 1'b1;
    bus.alucode     = code;
    bus.aluop1_type = t1;
    bus.aluop2_type = t2;
    bus.srcreg1_num = rs1;
    bus.srcreg2_num = rs2;
    bus.dstreg_num  = rd;
    bus.imm         = imm;
  endtask

  // Called #1 after an edge with inputs set; checks outputs, then advances one clock.
  task automatic step();
    bit          acc, pop, ok;
    logic [31:0] w;
    check("in_ready", 32'(bus.in_ready), 32'(exp_ir.size() < 2));
    check("out_valid", 32'(bus.out_valid), 32'(exp_ir.size() > 0));
    if (exp_ir.size() > 0) begin
      check("out_ir", bus.out_ir, exp_ir[0]);
      check("out_addr", 32'(bus.out_addr), 32'(exp_addr[0]));
    end
    check("err_pulse", 32'(err_pulse), 32'(m_pulse));
    check("err_sticky", 32'(err_sticky), 32'(m_sticky));
    acc = bus.in_valid && (exp_ir.size() < 2);
    pop = bus.out_ready && (exp_ir.size() > 0);
    ok  = ref_encode(bus.alucode, bus.aluop1_type, bus.aluop2_type, bus.srcreg1_num,
                     bus.srcreg2_num, bus.dstreg_num, bus.imm, w);
    @(posedge clk);
    m_pulse = 1'b0;
    if (addr_clr) begin
      exp_ir.delete();
      exp_addr.delete();
      m_addr   = AddrW'(Base);
      m_sticky = 1'b0;
    end else begin
      if (pop) begin
        void'(exp_ir.pop_front());
        void'(exp_addr.pop_front());
      end
      if (acc && ok) begin
        exp_ir.push_back(w);
        exp_addr.push_back(m_addr);
        m_addr = m_addr + AddrW'(4);
      end else if (acc) begin
        m_pulse  = 1'b1;
        m_sticky = 1'b1;
      end
    end
    #1;
  endtask

  task automatic clr();
    bus.in_valid = 1'b0;
    addr_clr     = 1'b1;
    step();
    addr_clr     = 1'b0;
  endtask

  task automatic rand_bundle();
    int unsigned r;
    logic [31:0] imm;
    r = $urandom_range(0, 33);
    case ($urandom_range(0, 3))
      0:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      1:       imm = $urandom;
      2:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      default: imm = 32'($urandom_range(0, 40));
    endcase
    drive((r > 31) ? 6'd63 : 6'(r), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          5'($urandom), 5'($urandom), 5'($urandom), imm);
  endtask

  initial begin
    rst = 1'b1;
    addr_clr = 1'b0;
    bus.out_ready = 1'b0;
    drive(6'd0, OpNone, OpNone, 5'd0, 5'd0, 5'd0, 32'd0);
    bus.in_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_ir", bus.out_ir, 32'd0);
    check("rst_out_addr", 32'(bus.out_addr), Base);
    check("rst_err", {30'd0, err_pulse, err_sticky}, 32'd0);
    rst = 1'b0;

    // ADDI x1,x0,5
    bus.out_ready = 1'b1;
    drive(AluAdd, OpReg, OpImm, 5'd0, 5'd0, 5'd1, 32'd5);
    step();
    bus.in_valid = 1'b0;
    check("addi_ir", bus.out_ir, 32'h00500093);
    check("addi_addr", 32'(bus.out_addr), 32'd0);
    step();
    clr();

    // LUI x2 then SUB x3,x1,x2
    drive(AluLui, OpImm, OpNone, 5'd0, 5'd0, 5'd2, 32'h12345000);
    step();
    check("lui_ir", bus.out_ir, 32'h12345137);
    check("lui_addr", 32'(bus.out_addr), 32'd0);
    drive(AluSub, OpReg, OpReg, 5'd1, 5'd2, 5'd3, 32'd0);
    step();
    bus.in_valid = 1'b0;
    check("sub_ir", bus.out_ir, 32'h402081B3);
    check("sub_addr", 32'(bus.out_addr), 32'd4);
    step();
    clr();

    // BEQ x1,x2,8 then SW x2,12(x1)
    drive(AluBeq, OpReg, OpReg, 5'd1, 5'd2, 5'd0, 32'd8);
    step();
    check("beq_ir", bus.out_ir, 32'h00208463);
    drive(AluSw, OpReg, OpReg, 5'd1, 5'd2, 5'd0, 32'd12);
    step();
    bus.in_valid = 1'b0;
    check("sw_ir", bus.out_ir, 32'h0020A623);
    check("sw_addr", 32'(bus.out_addr), 32'd4);
    step();
    clr();

    // Backpressure: three bundles offered, two fit
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(AluAdd, OpReg, OpImm, 5'd0, 5'd0, 5'(i + 1), 32'(i));
      step();
    end
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    check("bp_first_addr", 32'(bus.out_addr), 32'd0);
    step();
    check("bp_second_addr", 32'(bus.out_addr), 32'd4);
    step();
    bus.in_valid = 1'b0;
    check("bp_third_addr", 32'(bus.out_addr), 32'd8);
    check("bp_third_ir", bus.out_ir, 32'h00200193);
    step();
    clr();

    // Out-of-range I immediate
    drive(AluAdd, OpReg, OpImm, 5'd0, 5'd0, 5'd1, 32'd4096);
    step();
    bus.in_valid = 1'b0;
`ifdef INST_ENC_RANGE_CHECK_EN
    check("range_pulse", 32'(err_pulse), 32'd1);
    check("range_sticky", 32'(err_sticky), 32'd1);
    check("range_no_out", 32'(bus.out_valid), 32'd0);
    step();
    check("range_pulse_gone", 32'(err_pulse), 32'd0);
    drive(AluAdd, OpReg, OpImm, 5'd0, 5'd0, 5'd1, 32'd5);
    step();
    bus.in_valid = 1'b0;
    check("range_next_addr", 32'(bus.out_addr), 32'd0);
`else
    check("trunc_ir", bus.out_ir, 32'h00000093);
    check("trunc_addr", 32'(bus.out_addr), 32'd0);
`endif
    step();
    clr();

    // Unknown alucode, then addr_clr clears sticky and the counter
    drive(6'd63, OpReg, OpReg, 5'd1, 5'd2, 5'd3, 32'd0);
    step();
    check("bad_code_pulse", 32'(err_pulse), 32'd1);
    check("bad_code_sticky", 32'(err_sticky), 32'd1);
    drive(AluAdd, OpReg, OpReg, 5'd1, 5'd2, 5'd3, 32'd0);
    step();
    step();
    clr();
    check("clr_sticky", 32'(err_sticky), 32'd0);
    drive(AluAdd, OpReg, OpReg, 5'd1, 5'd2, 5'd3, 32'd0);
    step();
    bus.in_valid = 1'b0;
    check("clr_addr", 32'(bus.out_addr), Base);
    step();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      addr_clr      = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) != 0) rand_bundle();
      else bus.in_valid = 1'b0;
      step();
    end
    addr_clr = 1'b0;

    // Reset with two words buffered
    bus.out_ready = 1'b0;
    drive(AluJal, OpNone, OpNone, 5'd0, 5'd0, 5'd1, 32'd16);
    step();
    step();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #2;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_addr", 32'(bus.out_addr), Base);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(AluJalr, OpReg, OpImm, 5'd1, 5'd0, 5'd0, 32'd0);
    step();
    bus.in_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
